aes_key_schedule_seq: RTL and testbench

Sequential AES key-schedule engine supporting AES-128, AES-192 and AES-256, with the key length selected at run time per request. It produces one expanded word per clock through a single shared S-box lookup and stores all round keys in an internal buffer. Cipher round logic reads that buffer by round index. It replaces the purely combinational, fixed-Nk key expansion in the AES datapath.

---
 rtl/aes_key_schedule_seq.sv | 106 ++++++++++
 tb/tb_aes_key_schedule_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: one-word-per-cycle AES-128/192/256 key expansion into a round-key buffer.
// Define AES_KS_DEC_ORDER_EN to make rd_round r return round key nr-r (decryption order).
module aes_key_schedule_seq #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  output logic [3:0]   nr,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  localparam int DEPTH = 4 * (MAX_NK + 7);
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state, state_nx;
  logic [31:0] w [DEPTH];
  logic [5:0]  i, rb;
  logic [3:0]  nk, nk_in, rsel;
  logic [2:0]  m;
  logic [7:0]  rcon;
  logic        legal, accept, last;
  logic [31:0] prev, old, sub_in, sub_out, temp;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p ^= b[k] ? x : 8'h00;
      x = xt(x);
    end
    return p;
  endfunction
  // inverse as a^254 via square-and-multiply, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    t = a;
    for (int k = 0; k < 6; k++) t = gmul(gmul(t, t), a);
    t = gmul(t, t);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
  endfunction
  assign nk_in  = key_len == 2'd0 ? 4'd4 : key_len == 2'd1 ? 4'd6 : 4'd8;
  assign legal  = key_len != 2'd3 && int'(nk_in) <= MAX_NK;
  assign accept = state == IDLE && start && legal;
  assign last   = i == ({nk, 2'b00} + 6'd27);
  always_comb begin
    prev    = w[i - 6'd1];
    old     = w[i - {2'b00, nk}];
    sub_in  = m == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    temp    = m == 3'd0 ? sub_out ^ {rcon, 24'h0} : (nk == 4'd8 && m == 3'd4) ? sub_out : prev;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (accept ? EXPAND : IDLE) : (last ? IDLE : EXPAND);
  always_comb busy = state == EXPAND;
  always_ff @(posedge clk)
    if (accept) for (int k = 0; k < MAX_NK; k++) w[6'(k)] <= key_in[255 - 32*k -: 32];
    else if (state == EXPAND) w[i] <= old ^ temp;
`ifdef AES_KS_DEC_ORDER_EN
  assign rsel = nr - rd_round;
`else
  assign rsel = rd_round;
`endif
  assign rb = {rsel, 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      i <= '0;
      nk <= '0;
      m <= '0;
      rcon <= '0;
      nr <= '0;
      keys_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rd_key <= '0;
    end else begin
      done <= state == EXPAND && last;
      err <= state == IDLE && start && !legal;
      if (accept) begin
        i <= {2'b00, nk_in};
        nk <= nk_in;
        nr <= nk_in + 4'd6;
        m <= '0;
        rcon <= 8'h01;
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        i <= i + 6'd1;
        m <= m == 3'(nk - 4'd1) ? 3'd0 : m + 3'd1;
        if (m == 3'd0) rcon <= xt(rcon);
        if (last) keys_valid <= 1'b1;
      end
      rd_key <= (state == EXPAND || !keys_valid || rd_round > nr) ? '0 :
                {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]};
    end
  end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: randomized scoreboard bench against a FIPS-197 style key expansion model.
module tb_aes_key_schedule_seq;
  logic         clk = 0, rst = 1, start = 0;
  logic [1:0]   key_len = 0;
  logic [255:0] key_in = '0;
  logic         busy, done, err, keys_valid;
  logic [3:0]   nr, rd_round = 0;
  logic [127:0] rd_key;
  aes_key_schedule_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .keys_valid(keys_valid), .nr(nr),
    .rd_round(rd_round), .rd_key(rd_key)
  );
  always #5 clk = ~clk;
  typedef struct {logic [127:0] v; int r;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, t0 = 0;
  logic rd_req = 0, rd_req_d = 0;
  logic [7:0]  sb_t [256];
  logic [7:0]  rcon_t [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] mw [60];
  logic        mv = 0;
  int          mnr = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p ^= 15'(a) << k;
    for (int k = 14; k >= 8; k--) if (p[k]) p ^= 15'h11b << (k - 8);
    return p[7:0];
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_t[x[31:24]], sb_t[x[23:16]], sb_t[x[15:8]], sb_t[x[7:0]]};
  endfunction
  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    for (int k = 0; k < nk; k++) mw[k] = key[255 - 32*k -: 32];
    for (int k = nk; k < 4*(nk+7); k++) begin
      t = mw[k-1];
      if (k % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[k/nk], 24'h0};
      else if (nk == 8 && k % 8 == 4) t = subw(t);
      mw[k] = mw[k-nk] ^ t;
    end
  endtask
  function automatic int didx(input int e);
`ifdef AES_KS_DEC_ORDER_EN
    return mnr - e;
`else
    return e;
`endif
  endfunction
  function automatic logic [127:0] exp_rd(input int r);
    int x;
    if (!mv || r > mnr) return '0;
    x = didx(r);
    return {mw[4*x], mw[4*x+1], mw[4*x+2], mw[4*x+3]};
  endfunction
  always @(posedge clk) rd_req_d <= rd_req;
  always @(negedge clk)
    if (rd_req_d) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_underflow got=read want=none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("rd_r%0d", e.r), rd_key, e.v);
      end
    end
  task automatic rd(input int r, input logic [127:0] v);
    exp_t e;
    e.r = r;
    e.v = v;
    q.push_back(e);
    rd_round = 4'(r);
    rd_req = 1;
    @(posedge clk);
    #1 rd_req = 0;
  endtask
  task automatic go(input logic [1:0] len, input logic [255:0] k);
    key_len = len;
    key_in = k;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = cyc;
    if (len != 2'd3) begin
      mv = 0;
      mnr = 4*len + 4 - 2*len + 6;
      model_expand(k, mnr - 6);
    end
  endtask
  task automatic wait_done(input int lat, input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({nm, "_lat"}, 128'(cyc - t0), 128'(lat));
    chk({nm, "_busy"}, 128'(busy), 0);
    chk({nm, "_valid"}, 128'(keys_valid), 1);
    chk({nm, "_nr"}, 128'(nr), 128'(mnr));
    mv = 1;
  endtask
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  initial begin
    logic [255:0] rk;
    int len;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s, c;
      inv = 0;
      for (int y = 1; y < 256; y++) if (x != 0 && pmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      c = 8'h63;
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb_t[x] = s;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {busy, done, err, keys_valid, nr, rd_key}, '0);
    rst = 0;
    @(negedge clk);
    go(2'd0, K128);
    rd(0, 128'h0);
    wait_done(40, "aes128");
    rd(didx(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(didx(0), 128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int r = 0; r <= 10; r++) rd(r, exp_rd(r));
    rd(11, 128'h0);
    @(negedge clk);
    go(2'd3, ~K128);
    @(negedge clk);
    chk("illegal_err", 128'(err), 1);
    chk("illegal_valid", {busy, keys_valid, nr}, {1'b0, 1'b1, 4'd10});
    @(negedge clk);
    chk("err_pulse", 128'(err), 0);
    rd(didx(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    go(2'd1, K192);
    wait_done(46, "aes192");
    rd(didx(12), 128'he98ba06f448c773c8ecc720401002202);
    go(2'd2, K256);
    wait_done(52, "aes256");
    rd(didx(14), 128'hfe4890d1e6188d0b046df344706c631e);
    rd(15, 128'h0);
    rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    go(2'd0, rk);
    repeat (10) @(posedge clk);
    #1 key_len = 2'd2;
    key_in = ~rk;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("busy_start_err", {err, busy}, {1'b0, 1'b1});
    wait_done(40, "ignored");
    rd(10, exp_rd(10));
    rd(3, exp_rd(3));
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(0, 2);
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      go(2'(len), rk);
      wait_done(4*(mnr+1) - (mnr-6), $sformatf("rand%0d", it));
      if (it % 3 != 2)
        for (int j = 0; j < 3; j++) begin
          int r;
          r = $urandom_range(0, 15);
          rd(r, exp_rd(r));
        end
    end
    @(negedge clk);
    go(2'd2, K256);
    repeat (19) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    mv = 0;
    mnr = 0;
    @(negedge clk);
    chk("mid_rst", {busy, done, err, keys_valid, nr, rd_key}, '0);
    rd(0, exp_rd(0));
    go(2'd0, K128);
    wait_done(40, "after_rst");
    rd(didx(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(1, exp_rd(1));
    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
